// File: rtl/sram_arbiter.sv
// Two-port (CPU / debug) arbiter sharing one asynchronous SRAM through a GRANT/ACCESS/DONE sequence.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN swaps fixed CPU priority for alternating grants.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        OE,
  output logic        WE,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic        r_we;
  logic        r_sel_dbg;
  logic [15:0] r_wdata;
  logic [3:0]  r_cnt;
  logic        w_any_req;
  logic        w_pick_dbg;
  logic        w_win_we;

  assign w_any_req = cpu_req | dbg_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic r_last_dbg;
  // On contention the port that did not win last time gets the bus.
  assign w_pick_dbg = dbg_req & (~cpu_req | ~r_last_dbg);
`else
  assign w_pick_dbg = dbg_req & ~cpu_req;
`endif

  assign w_win_we = w_pick_dbg ? dbg_we : cpu_we;

  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_sel_dbg    <= 1'b0;
      r_wdata      <= 16'h0000;
      r_cnt        <= 4'd0;
      ADDR         <= 16'h0000;
      Data_to_SRAM <= 16'h0000;
      OE           <= 1'b1;
      WE           <= 1'b1;
      cpu_ack      <= 1'b0;
      dbg_ack      <= 1'b0;
      cpu_rdata    <= 16'h0000;
      dbg_rdata    <= 16'h0000;
      busy         <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      r_last_dbg   <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= GRANT;
            busy      <= 1'b1;
            r_sel_dbg <= w_pick_dbg;
            r_we      <= w_win_we;
            ADDR      <= w_pick_dbg ? dbg_addr : cpu_addr;
            r_wdata   <= w_pick_dbg ? dbg_wdata : cpu_wdata;
            // Reads open the output enable already in GRANT.
            OE        <= w_win_we;
            WE        <= 1'b1;
          end
        end
        GRANT: begin
          r_state <= ACCESS;
          r_cnt   <= LP_CNT_LOAD;
          OE      <= r_we;
          WE      <= ~r_we;
          if (r_we) begin
            Data_to_SRAM <= r_wdata;
          end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          r_last_dbg <= r_sel_dbg;
`endif
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            OE      <= 1'b1;
            WE      <= 1'b1;
            cpu_ack <= ~r_sel_dbg;
            dbg_ack <= r_sel_dbg;
            if (!r_we) begin
              if (r_sel_dbg) begin
                dbg_rdata <= Data_from_SRAM;
              end else begin
                cpu_rdata <= Data_from_SRAM;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: WAIT_CYCLES=2 instance for protocol tests, WAIT_CYCLES=15 for latency.
module tb_sram_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_ah;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, Data_from_SRAM;
  logic        cpu_ack, dbg_ack, OE, WE, busy;
  logic [15:0] cpu_rdata, dbg_rdata, ADDR, Data_to_SRAM;

  logic        s_rst;
  logic        s_cpu_req, s_cpu_we, s_dbg_req, s_dbg_we;
  logic [15:0] s_cpu_addr, s_cpu_wdata, s_dbg_addr, s_dbg_wdata, s_din;
  logic        s_cpu_ack, s_dbg_ack, s_oe, s_we, s_busy;
  logic [15:0] s_cpu_rdata, s_dbg_rdata, s_addr, s_dout;

  int tests_run = 0;
  int tests_failed = 0;
  int overlap_main = 0;
  int overlap_w15 = 0;

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset_ah(Reset_ah),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .OE(OE), .WE(WE), .busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(Clk), .Reset_ah(s_rst),
    .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
    .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata),
    .dbg_req(s_dbg_req), .dbg_we(s_dbg_we), .dbg_addr(s_dbg_addr), .dbg_wdata(s_dbg_wdata),
    .dbg_ack(s_dbg_ack), .dbg_rdata(s_dbg_rdata),
    .ADDR(s_addr), .Data_to_SRAM(s_dout), .Data_from_SRAM(s_din),
    .OE(s_oe), .WE(s_we), .busy(s_busy)
  );

  // Strobe overlap watcher, sampled away from the active edge.
  always @(negedge Clk) begin
    if (OE === 1'b0 && WE === 1'b0) overlap_main++;
    if (s_oe === 1'b0 && s_we === 1'b0) overlap_w15++;
  end

  task automatic test_reset;
    Reset_ah = 1'b0; s_rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; Data_from_SRAM = 0;
    s_cpu_req = 0; s_cpu_we = 0; s_cpu_addr = 0; s_cpu_wdata = 0;
    s_dbg_req = 0; s_dbg_we = 0; s_dbg_addr = 0; s_dbg_wdata = 0; s_din = 0;
    #1 Reset_ah = 1'b1; s_rst = 1'b1;
    repeat (2) @(negedge Clk);
    tests_run++;
    if ({OE, WE, cpu_ack, dbg_ack, busy} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got OE,WE,cack,dack,busy=%b required 11000", {OE, WE, cpu_ack, dbg_ack, busy});
    end
    tests_run++;
    if ({ADDR, Data_to_SRAM, cpu_rdata, dbg_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h required all zero", ADDR, Data_to_SRAM, cpu_rdata, dbg_rdata);
    end
    tests_run++;
    if ({s_oe, s_we, s_busy, s_cpu_ack} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_w15: got %b required 1100", {s_oe, s_we, s_busy, s_cpu_ack});
    end
    Reset_ah = 1'b0; s_rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_cpu_read;
    logic exp_oe, exp_ack, exp_busy;
    @(negedge Clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012; Data_from_SRAM = 16'hBEEF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (k == 1) cpu_req = 0;
      exp_oe   = !(k >= 1 && k <= 3);
      exp_ack  = (k == 4);
      exp_busy = (k >= 1 && k <= 4);
      tests_run++;
      if ({OE, WE, cpu_ack, dbg_ack, busy} !== {exp_oe, 1'b1, exp_ack, 1'b0, exp_busy}) begin
        tests_failed++;
        $display("FAIL cpu_read_c%0d: got OE,WE,cack,dack,busy=%b required %b", k,
                 {OE, WE, cpu_ack, dbg_ack, busy}, {exp_oe, 1'b1, exp_ack, 1'b0, exp_busy});
      end
      if (k <= 3) begin
        tests_run++;
        if (ADDR !== 16'h0012) begin
          tests_failed++;
          $display("FAIL cpu_read_addr_c%0d: got %h required 0012", k, ADDR);
        end
      end
    end
    tests_run++;
    if (cpu_rdata !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL cpu_read_data: got %h required beef", cpu_rdata);
    end
    $display("[TB] cpu read 0012 -> %h", cpu_rdata);
  endtask

  task automatic test_dbg_read;
    int acks;
    acks = 0;
    @(negedge Clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0100; Data_from_SRAM = 16'h5A5A;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (k == 1) dbg_req = 0;
      if (dbg_ack) acks++;
      tests_run++;
      if (cpu_ack !== 1'b0 || dbg_ack !== (k == 4)) begin
        tests_failed++;
        $display("FAIL dbg_read_ack_c%0d: got cack=%b dack=%b required 0 %b", k, cpu_ack, dbg_ack, (k == 4));
      end
    end
    tests_run++;
    if (dbg_rdata !== 16'h5A5A || cpu_rdata !== 16'hBEEF || acks != 1) begin
      tests_failed++;
      $display("FAIL dbg_read_data: got dbg=%h cpu=%h acks=%0d required 5a5a beef 1", dbg_rdata, cpu_rdata, acks);
    end
    $display("[TB] dbg read 0100 -> %h", dbg_rdata);
  endtask

  task automatic test_dbg_write;
    int we_low, oe_low, acks;
    we_low = 0; oe_low = 0; acks = 0;
    @(negedge Clk);
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h3000; dbg_wdata = 16'h1234; Data_from_SRAM = 16'hFFFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (k == 1) dbg_req = 0;
      if (!WE) we_low++;
      if (!OE) oe_low++;
      if (dbg_ack) acks++;
      if (k == 2 || k == 3) begin
        tests_run++;
        if (WE !== 1'b0 || Data_to_SRAM !== 16'h1234 || ADDR !== 16'h3000) begin
          tests_failed++;
          $display("FAIL dbg_write_c%0d: got WE=%b data=%h addr=%h required 0 1234 3000", k, WE, Data_to_SRAM, ADDR);
        end
      end
    end
    tests_run++;
    if (we_low != 2 || oe_low != 0 || acks != 1) begin
      tests_failed++;
      $display("FAIL dbg_write_strobes: got we_low=%0d oe_low=%0d acks=%0d required 2 0 1", we_low, oe_low, acks);
    end
    tests_run++;
    if (dbg_rdata !== 16'h5A5A || cpu_rdata !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL dbg_write_rdata: got dbg=%h cpu=%h required 5a5a beef", dbg_rdata, cpu_rdata);
    end
    $display("[TB] dbg write 3000 <- 1234, WE low %0d cycles", we_low);
  endtask

  task automatic test_arbitration;
    logic seq [4];
    logic exp_dbg;
    int n;
    n = 0;
    @(negedge Clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0A00;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0B00; Data_from_SRAM = 16'h1111;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge Clk);
      tests_run++;
      if (cpu_ack === 1'b1 && dbg_ack === 1'b1) begin
        tests_failed++;
        $display("FAIL arb_dual_ack: got both acks high required at most one");
      end
      if (cpu_ack || dbg_ack) begin
        seq[n] = dbg_ack;
        n++;
        if (n == 4) begin
          cpu_req = 0; dbg_req = 0;
        end
      end
    end
    cpu_req = 0; dbg_req = 0;
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL arb_count: got %0d acks required 4", n);
    end
    for (int i = 0; i < n; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_dbg = (i % 2 == 1);
`else
      exp_dbg = 1'b0;
`endif
      tests_run++;
      if (seq[i] !== exp_dbg) begin
        tests_failed++;
        $display("FAIL arb_order_%0d: got dbg=%b required %b", i, seq[i], exp_dbg);
      end
    end
    repeat (2) @(negedge Clk);
    $display("[TB] arbitration: %0d acks observed", n);
  endtask

  task automatic test_addr_hold;
    @(negedge Clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; Data_from_SRAM = 16'h2222;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      if (k == 1) cpu_req = 0;
      if (k == 2) cpu_addr = 16'h0020;
      if (k <= 4) begin
        tests_run++;
        if (ADDR !== 16'h0010) begin
          tests_failed++;
          $display("FAIL addr_hold_c%0d: got %h required 0010", k, ADDR);
        end
      end
    end
    tests_run++;
    if (cpu_rdata !== 16'h2222) begin
      tests_failed++;
      $display("FAIL addr_hold_data: got %h required 2222", cpu_rdata);
    end
    $display("[TB] address held at %h across input change", ADDR);
  endtask

  task automatic test_reset_mid_write;
    @(negedge Clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'hCAFE;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      if (k == 1) cpu_req = 0;
    end
    tests_run++;
    if (WE !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got WE=%b required 0", WE);
    end
    Reset_ah = 1'b1;
    #1;
    tests_run++;
    if ({OE, WE, cpu_ack, dbg_ack, busy} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL rst_mid_ctrl: got OE,WE,cack,dack,busy=%b required 11000", {OE, WE, cpu_ack, dbg_ack, busy});
    end
    tests_run++;
    if ({ADDR, Data_to_SRAM, cpu_rdata, dbg_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_data: got %h %h %h %h required all zero", ADDR, Data_to_SRAM, cpu_rdata, dbg_rdata);
    end
    @(negedge Clk);
    Reset_ah = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      tests_run++;
      if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_mid_after_c%0d: got cack=%b dack=%b busy=%b required 0 0 0", k, cpu_ack, dbg_ack, busy);
      end
    end
    $display("[TB] reset during write access aborted transfer");
  endtask

  task automatic test_wait15;
    @(negedge Clk);
    s_cpu_req = 1; s_cpu_we = 0; s_cpu_addr = 16'h0077; s_din = 16'h1357;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (k == 1) s_cpu_req = 0;
      tests_run++;
      if (s_cpu_ack !== (k == 17) || s_busy !== (k <= 17)) begin
        tests_failed++;
        $display("FAIL w15_c%0d: got ack=%b busy=%b required %b %b", k, s_cpu_ack, s_busy, (k == 17), (k <= 17));
      end
    end
    tests_run++;
    if (s_cpu_rdata !== 16'h1357) begin
      tests_failed++;
      $display("FAIL w15_data: got %h required 1357", s_cpu_rdata);
    end
    $display("[TB] wait15 read 0077 -> %h", s_cpu_rdata);
  endtask

  task automatic test_no_overlap;
    tests_run++;
    if (overlap_main != 0 || overlap_w15 != 0) begin
      tests_failed++;
      $display("FAIL strobe_overlap: got %0d/%0d cycles with OE and WE low required 0/0", overlap_main, overlap_w15);
    end
    $display("[TB] strobe overlap cycles %0d/%0d", overlap_main, overlap_w15);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_read();
    test_dbg_write();
    test_arbitration();
    test_addr_hold();
    test_reset_mid_write();
    test_wait15();
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, number of ACCESS-state cycles per transfer (legal range 1..15).
REQ-002 SHALL provide input Clk, 1 bit, system clock; all state changes on rising edge.
REQ-003 SHALL provide input Reset_ah, 1 bit, reset: asynchronous, active-high.
REQ-004 SHALL provide cpu_req in 1, cpu_we in 1, cpu_addr in 16, cpu_wdata in 16: CPU port request, write-enable, address, write data.
REQ-005 SHALL provide cpu_ack out 1, cpu_rdata out 16: CPU completion pulse and read data.
REQ-006 SHALL provide dbg_req in 1, dbg_we in 1, dbg_addr in 16, dbg_wdata in 16, dbg_ack out 1, dbg_rdata out 16: debug/loader port, same meanings.
REQ-007 SHALL provide ADDR out 16, Data_to_SRAM out 16, Data_from_SRAM in 16, OE out 1 (active-low), WE out 1 (active-low): shared SRAM side.
REQ-008 SHALL provide busy out 1: high in every state except IDLE.

Function
REQ-009 SHALL implement FSM IDLE -> GRANT -> ACCESS -> DONE -> IDLE; no other transitions except reset.
REQ-010 IDLE: if any req high, go to GRANT next edge and latch winner's we/addr/wdata; else stay.
REQ-011 Arbitration (macro absent): fixed priority, CPU wins when both req high.
REQ-012 GRANT: ADDR driven from latched address; OE low if read; WE high; one cycle.
REQ-013 ACCESS: lasts exactly WAIT_CYCLES cycles via 4-bit down-counter loaded in GRANT; read keeps OE low, WE high; write drives OE high, WE low, Data_to_SRAM = latched wdata.
REQ-014 On last ACCESS cycle of a read, Data_from_SRAM SHALL be captured into winner's rdata register.
REQ-015 DONE: OE=WE=1, winner's ack high for exactly this one cycle; other ack stays 0.
REQ-016 Latency: req sampled in IDLE at cycle 0 -> ack in cycle WAIT_CYCLES+2; rdata valid from that cycle.
REQ-017 cpu_rdata/dbg_rdata SHALL hold value until that port's next completed read; writes never alter them.
REQ-018 Requester inputs are ignored after latching; changes to req/addr/data during GRANT/ACCESS/DONE have no effect.
REQ-019 Req still high in IDLE after DONE SHALL be treated as a new request (requester drops req in ack cycle for single transfer).
REQ-020 Outside GRANT/ACCESS: ADDR holds last latched value, Data_to_SRAM holds last value, OE=WE=1.
REQ-021 OE and WE SHALL never be low in the same cycle.

Reset
REQ-022 Reset_ah high SHALL immediately force IDLE, OE=1, WE=1, cpu_ack=dbg_ack=0, busy=0, ADDR=0, Data_to_SRAM=0, cpu_rdata=dbg_rdata=0, counter=0, last-grant=debug.
REQ-023 Reset mid-transfer SHALL abort it with no ack; write strobe deasserts asynchronously.
REQ-024 After Reset_ah falls, first arbitration occurs on first rising edge with a req high.

Configuration
REQ-025 Macro SRAM_ARB_ROUND_ROBIN_EN defined: when both req high in IDLE, grant goes to port not granted last; single requester always wins; last-grant updated on each GRANT.
REQ-026 Macro undefined: fixed CPU priority per REQ-011; last-grant register absent.

Verification
REQ-027 CPU read alone, WAIT_CYCLES=2, cpu_addr=16'h0012, SRAM returns 16'hBEEF -> OE low cycles 1-3, cpu_ack high cycle 4 only, cpu_rdata=16'hBEEF.
REQ-028 dbg write addr 16'h3000 data 16'h1234 -> WE low exactly 2 cycles, OE high throughout, Data_to_SRAM=16'h1234, dbg_ack one pulse, dbg_rdata unchanged.
REQ-029 cpu_req and dbg_req both held high 4 transfers, no macro -> all 4 acks to CPU; with SRAM_ARB_ROUND_ROBIN_EN -> CPU, dbg, CPU, dbg.
REQ-030 Reset_ah pulsed during second ACCESS cycle of write -> WE=1 same cycle, no ack, all outputs at REQ-022 values.
REQ-031 cpu_addr changed from 16'h0010 to 16'h0020 during ACCESS -> ADDR stays 16'h0010 until DONE.
REQ-032 WAIT_CYCLES=15 read -> ack exactly 17 cycles after request sampled; OE/WE never both low over whole run.
